// File: rtl/bus_gate_arbiter.sv
// Round-robin arbiter gating the PC/MARMUX/MDR/ALU drivers onto DataBus.
// Registered one-hot enables, one-cycle grant latency, bounded hold, optional idle turnaround.
module bus_gate_arbiter #(
    parameter int MAX_HOLD   = 4,
    parameter int TURNAROUND = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [3:0] req,
    output logic       PC_enable,
    output logic       MARMUX_enable,
    output logic       MDR_enable,
    output logic       ALU_enable,
    output logic [1:0] gnt_id,
    output logic       bus_valid,
    output logic       grant_start
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_last;
    logic [3:0] r_hold;
    logic [3:0] r_en;
    logic [1:0] r_gnt_id;
    logic       r_valid;
    logic       r_start;

    logic       w_found;
    logic [1:0] w_win;
    logic       w_others;
    logic       w_stay;
    logic       w_grant;

    // Scan upward from the slot after the last owner; the last owner is visited last,
    // so it only wins again when nobody else is asking.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && req[r_last + 2'(k)]) begin
                w_found = 1'b1;
                w_win   = r_last + 2'(k);
            end
        end
    end

    assign w_others = |(req & ~(4'b0001 << r_last));
    assign w_stay   = (r_state == GRANT) && req[r_last] && ((r_hold < HOLD_LAST) || !w_others);

    always_comb begin
        w_grant = 1'b0;
        case (r_state)
            IDLE, TURN: w_grant = w_found;
            GRANT:      w_grant = !w_stay && (TURNAROUND == 0) && w_found;
            default:    w_grant = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_last   <= 2'd3;
            r_hold   <= 4'd0;
            r_en     <= 4'd0;
            r_gnt_id <= 2'd0;
            r_valid  <= 1'b0;
            r_start  <= 1'b0;
        end else if (w_grant) begin
            r_state  <= GRANT;
            r_last   <= w_win;
            r_hold   <= 4'd0;
            r_en     <= 4'b0001 << w_win;
            r_gnt_id <= w_win;
            r_valid  <= 1'b1;
            r_start  <= 1'b1;
        end else if (w_stay) begin
            if (r_hold < HOLD_LAST) begin
                r_hold <= r_hold + 4'd1;
            end
            r_start <= 1'b0;
        end else begin
            // Released with turnaround enabled, or nothing left to serve.
            r_state  <= ((r_state == GRANT) && (TURNAROUND != 0)) ? TURN : IDLE;
            r_hold   <= 4'd0;
            r_en     <= 4'd0;
            r_gnt_id <= 2'd0;
            r_valid  <= 1'b0;
            r_start  <= 1'b0;
        end
    end

    assign PC_enable     = r_en[0];
    assign MARMUX_enable = r_en[1];
    assign MDR_enable    = r_en[2];
    assign ALU_enable    = r_en[3];
    assign gnt_id        = r_gnt_id;
    assign bus_valid     = r_valid;
    assign grant_start   = r_start;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed and random checks of bus_gate_arbiter with turnaround on (dut_a) and off (dut_b).
module tb_bus_gate_arbiter;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [3:0] req_a;
    logic [3:0] req_b;

    logic       a_pc, a_mar, a_mdr, a_alu, a_valid, a_start;
    logic [1:0] a_gnt;
    logic       b_pc, b_mar, b_mdr, b_alu, b_valid, b_start;
    logic [1:0] b_gnt;
    logic [3:0] en_a;
    logic [3:0] en_b;

    int n_total = 0;
    int n_bad   = 0;

    assign en_a = {a_alu, a_mdr, a_mar, a_pc};
    assign en_b = {b_alu, b_mdr, b_mar, b_pc};

    always #5 Clk = ~Clk;

    bus_gate_arbiter #(.MAX_HOLD(4), .TURNAROUND(1)) dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .req(req_a),
        .PC_enable(a_pc), .MARMUX_enable(a_mar), .MDR_enable(a_mdr), .ALU_enable(a_alu),
        .gnt_id(a_gnt), .bus_valid(a_valid), .grant_start(a_start)
    );

    bus_gate_arbiter #(.MAX_HOLD(4), .TURNAROUND(0)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .req(req_b),
        .PC_enable(b_pc), .MARMUX_enable(b_mar), .MDR_enable(b_mdr), .ALU_enable(b_alu),
        .gnt_id(b_gnt), .bus_valid(b_valid), .grant_start(b_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp_a(input string tag, input logic [3:0] en, input logic [1:0] g, input logic st);
        check({tag, "_en"},    32'(en_a),    32'(en));
        check({tag, "_gnt"},   32'(a_gnt),   32'(g));
        check({tag, "_start"}, 32'(a_start), 32'(st));
        check({tag, "_valid"}, 32'(a_valid), 32'(|en));
    endtask

    task automatic exp_b(input string tag, input logic [3:0] en, input logic [1:0] g, input logic st);
        check({tag, "_en"},    32'(en_b),    32'(en));
        check({tag, "_gnt"},   32'(b_gnt),   32'(g));
        check({tag, "_start"}, 32'(b_start), 32'(st));
        check({tag, "_valid"}, 32'(b_valid), 32'(|en));
    endtask

    initial begin
        int wa [4];
        int wb [4];
        int max_a;
        int max_b;

        Reset_n = 1'b0;
        req_a   = 4'bxxxx;
        req_b   = 4'bxxxx;
        repeat (3) @(negedge Clk);
        exp_a("rst_a", 4'b0000, 2'd0, 1'b0);
        exp_b("rst_b", 4'b0000, 2'd0, 1'b0);

        // Full load, turnaround on: PC, MARMUX, MDR, ALU, PC; 4 cycles each plus 1 idle.
        Reset_n = 1'b1;
        req_a   = 4'b1111;
        req_b   = 4'b0000;
        for (int c = 0; c <= 20; c++) begin
            int ph;
            int own;
            @(negedge Clk);
            ph  = c % 5;
            own = (c / 5) % 4;
            exp_a("rr", (ph < 4) ? (4'b0001 << own) : 4'b0000,
                  (ph < 4) ? 2'(own) : 2'd0, ph == 0);
        end
        req_a = 4'b0000;
        repeat (2) @(negedge Clk);

        // Sole MDR requester for 10 cycles: no forced release.
        req_a = 4'b0100;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            exp_a("solo", (k <= 10) ? 4'b0100 : 4'b0000, (k <= 10) ? 2'd2 : 2'd0, k == 1);
            if (k == 10) req_a = 4'b0000;
        end

        // PC drops after 2 cycles while MDR waits.
        req_a = 4'b0101;
        @(negedge Clk); exp_a("drop1", 4'b0001, 2'd0, 1'b1);
        @(negedge Clk); exp_a("drop2", 4'b0001, 2'd0, 1'b0);
        req_a = 4'b0100;
        @(negedge Clk); exp_a("drop_turn", 4'b0000, 2'd0, 1'b0);
        @(negedge Clk); exp_a("drop_mdr", 4'b0100, 2'd2, 1'b1);
        req_a = 4'b0000;
        repeat (2) @(negedge Clk);

        // No turnaround: PC for 4 cycles, ALU immediately after, then PC again.
        req_b = 4'b1001;
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            exp_b("b2b", (k <= 4 || k == 9) ? 4'b0001 : 4'b1000,
                  (k >= 5 && k <= 8) ? 2'd3 : 2'd0, k == 1 || k == 5 || k == 9);
        end
        req_b = 4'b0000;
        @(negedge Clk); exp_b("b2b_rel", 4'b0000, 2'd0, 1'b0);

        // Reset while ALU owns the bus.
        req_a = 4'b1000;
        @(negedge Clk); exp_a("alu_own", 4'b1000, 2'd3, 1'b1);
        @(negedge Clk);
        Reset_n = 1'b0;
        req_a   = 4'bxxxx;
        @(negedge Clk); exp_a("midrst", 4'b0000, 2'd0, 1'b0);
        Reset_n = 1'b1;
        req_a   = 4'b1111;
        @(negedge Clk); exp_a("post_rst_pc", 4'b0001, 2'd0, 1'b1);

        // Random traffic: one-hot enables and bounded waiting.
        req_b = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wa[i] = 0;
            wb[i] = 0;
        end
        max_a = 0;
        max_b = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge Clk);
            check("onehot_a", 32'($countones(en_a) <= 1), 32'd1);
            check("onehot_b", 32'($countones(en_b) <= 1), 32'd1);
            check("valid_a", 32'(a_valid), 32'(|en_a));
            check("valid_b", 32'(b_valid), 32'(|en_b));
            for (int i = 0; i < 4; i++) begin
                if (req_a[i] && !en_a[i]) wa[i]++; else wa[i] = 0;
                if (req_b[i] && !en_b[i]) wb[i]++; else wb[i] = 0;
                if (wa[i] > max_a) max_a = wa[i];
                if (wb[i] > max_b) max_b = wb[i];
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(7) == 0) req_a[i] = ~req_a[i];
                if ($urandom_range(7) == 0) req_b[i] = ~req_b[i];
            end
        end
        check("max_wait_a_le_16", 32'(max_a <= 16), 32'd1);
        check("max_wait_b_le_13", 32'(max_b <= 13), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
